vp_validate_unit: RTL and testbench

VP_VALIDATE_UNIT -- requirements
Module: vp_validate_unit

---
 rtl/vp_pkg.sv | 14 +
 rtl/vp_validate_unit_if.sv | 34 +++
 rtl/vp_validate_fifo.sv | 74 +++++++
 rtl/vp_validate_unit.sv | 160 ++++++++++++++++
 tb/tb_vp_validate_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vp_pkg.sv
// Shared types for the value-prediction validate unit: in-flight entry layout and err_o bit positions.
package vp_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        conf;
  } vp_entry_t;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_PCM = 2;

endpackage

// File: rtl/vp_validate_unit_if.sv
// Prediction/execution/feedback bundle; master drives pred/exe/flush, slave (the unit) returns feedback.
interface vp_validate_unit_if #(
  parameter int P_NUM_PRED = 2
);

  logic [P_NUM_PRED-1:0][31:0] pred_pc_i;
  logic [P_NUM_PRED-1:0][31:0] pred_result_i;
  logic [P_NUM_PRED-1:0]       pred_conf_i;
  logic [P_NUM_PRED-1:0]       pred_valid_i;
  logic [P_NUM_PRED-1:0][31:0] exe_pc_i;
  logic [P_NUM_PRED-1:0][31:0] exe_result_i;
  logic [P_NUM_PRED-1:0]       exe_valid_i;
  logic                        flush_i;
  logic [P_NUM_PRED-1:0][31:0] fb_pc_o;
  logic [P_NUM_PRED-1:0][31:0] fb_actual_o;
  logic [P_NUM_PRED-1:0]       fb_mispredict_o;
  logic [P_NUM_PRED-1:0]       fb_conf_o;
  logic [P_NUM_PRED-1:0]       fb_valid_o;
  logic                        full_o;
  logic [2:0]                  err_o;

  modport master (
    output pred_pc_i, pred_result_i, pred_conf_i, pred_valid_i,
    output exe_pc_i, exe_result_i, exe_valid_i, flush_i,
    input  fb_pc_o, fb_actual_o, fb_mispredict_o, fb_conf_o, fb_valid_o, full_o, err_o
  );

  modport slave (
    input  pred_pc_i, pred_result_i, pred_conf_i, pred_valid_i,
    input  exe_pc_i, exe_result_i, exe_valid_i, flush_i,
    output fb_pc_o, fb_actual_o, fb_mispredict_o, fb_conf_o, fb_valid_o, full_o, err_o
  );

endinterface

// File: rtl/vp_validate_fifo.sv
// Multi-write/multi-read circular buffer; writes and pops land on the next edge, heads readable combinationally.
// No internal backpressure: the caller only requests writes that fit after its pops.
module vp_validate_fifo
  import vp_pkg::*;
#(
  parameter int P_NUM_PRED   = 2,
  parameter int P_FIFO_DEPTH = 16,
  localparam int AW = $clog2(P_FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic      [P_NUM_PRED-1:0]       wr_vld_i,
  input  vp_entry_t [P_NUM_PRED-1:0]       wr_dat_i,
  input  logic      [CW-1:0]               rd_num_i,
  output vp_entry_t [P_NUM_PRED-1:0]       rd_dat_o,
  output logic      [CW-1:0]               count_o
);

  vp_entry_t         mem_q [P_FIFO_DEPTH];
  vp_entry_t         mem_d [P_FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_idx;
  logic [CW-1:0]     wr_num;

  // Valid write lanes are packed into consecutive slots, lane 0 first.
  always_comb begin
    mem_d  = mem_q;
    wr_idx = wr_ptr_q;
    wr_num = '0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      if (wr_vld_i[k]) begin
        mem_d[wr_idx] = wr_dat_i[k];
        wr_idx        = wr_idx + AW'(1);
        wr_num        = wr_num + CW'(1);
      end
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_idx;
      rd_ptr_d = rd_ptr_q + rd_num_i[AW-1:0];
      count_d  = count_q + wr_num - rd_num_i;
    end
  end

  always_comb begin
    for (int k = 0; k < P_NUM_PRED; k++) begin
      rd_dat_o[k] = mem_q[rd_ptr_q + AW'(k)];
    end
  end

  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vp_validate_unit.sv
// Matches executed results against queued value predictions; feedback is registered, 1 cycle after exe_valid.
// No stalls: excess predictions are dropped (err_o[0]); optional VP_VALIDATE_STATS_EN adds saturating counters.
module vp_validate_unit
  import vp_pkg::*;
#(
  parameter int P_NUM_PRED   = 2,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vp_validate_unit_if.slave bus
`ifdef VP_VALIDATE_STATS_EN
  ,
  output logic [31:0]       stat_pred_o,
  output logic [31:0]       stat_mispred_o,
  output logic [31:0]       stat_conf_mispred_o
`endif
);

  localparam int CW = $clog2(P_FIFO_DEPTH) + 1;

  vp_entry_t [P_NUM_PRED-1:0]       wr_dat, rd_dat;
  logic      [P_NUM_PRED-1:0]       wr_vld;
  logic      [CW-1:0]               count, pop_num, free_num, push_num;
  vp_entry_t                        head;
  logic      [2:0]                  err_new;

  logic [P_NUM_PRED-1:0][31:0] fb_pc_q, fb_pc_d, fb_actual_q, fb_actual_d;
  logic [P_NUM_PRED-1:0]       fb_mis_q, fb_mis_d, fb_conf_q, fb_conf_d, fb_valid_q, fb_valid_d;
  logic [2:0]                  err_q, err_d;

  always_comb begin
    pop_num = '0;
    err_new = '0;
    head    = '0;
    // Exe lanes consume heads in order; only entries present before this edge are visible.
    for (int k = 0; k < P_NUM_PRED; k++) begin
      fb_pc_d[k]     = '0;
      fb_actual_d[k] = '0;
      fb_mis_d[k]    = 1'b0;
      fb_conf_d[k]   = 1'b0;
      fb_valid_d[k]  = 1'b0;
      if (bus.exe_valid_i[k]) begin
        if (pop_num < count) begin
          for (int j = 0; j < P_NUM_PRED; j++) begin
            if (CW'(j) == pop_num) head = rd_dat[j];
          end
          fb_pc_d[k]     = head.pc;
          fb_actual_d[k] = bus.exe_result_i[k];
          fb_conf_d[k]   = head.conf;
          fb_mis_d[k]    = (head.result != bus.exe_result_i[k]);
          if (head.pc != bus.exe_pc_i[k]) err_new[ERR_PCM] = 1'b1;
          else                            fb_valid_d[k]    = 1'b1;
          pop_num = pop_num + CW'(1);
        end else begin
          err_new[ERR_UDF] = 1'b1;
        end
      end
    end

    free_num = CW'(P_FIFO_DEPTH) - count + pop_num;
    push_num = '0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      wr_dat[k] = '{pc: bus.pred_pc_i[k], result: bus.pred_result_i[k], conf: bus.pred_conf_i[k]};
      wr_vld[k] = 1'b0;
      if (bus.pred_valid_i[k] && !bus.flush_i) begin
        if (push_num < free_num) begin
          wr_vld[k] = 1'b1;
          push_num  = push_num + CW'(1);
        end else begin
          err_new[ERR_OVF] = 1'b1;
        end
      end
    end
    err_d = err_q | err_new;
  end

  vp_validate_fifo #(
    .P_NUM_PRED   (P_NUM_PRED),
    .P_FIFO_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (bus.flush_i),
    .wr_vld_i (wr_vld),
    .wr_dat_i (wr_dat),
    .rd_num_i (pop_num),
    .rd_dat_o (rd_dat),
    .count_o  (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fb_pc_q     <= '0;
      fb_actual_q <= '0;
      fb_mis_q    <= '0;
      fb_conf_q   <= '0;
      fb_valid_q  <= '0;
      err_q       <= '0;
    end else begin
      fb_pc_q     <= fb_pc_d;
      fb_actual_q <= fb_actual_d;
      fb_mis_q    <= fb_mis_d;
      fb_conf_q   <= fb_conf_d;
      fb_valid_q  <= fb_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.fb_pc_o         = fb_pc_q;
  assign bus.fb_actual_o     = fb_actual_q;
  assign bus.fb_mispredict_o = fb_mis_q;
  assign bus.fb_conf_o       = fb_conf_q;
  assign bus.fb_valid_o      = fb_valid_q;
  assign bus.err_o           = err_q;
  assign bus.full_o          = (CW'(P_FIFO_DEPTH) - count) < CW'(P_NUM_PRED);

`ifdef VP_VALIDATE_STATS_EN
  logic [31:0] stat_pred_q, stat_pred_d, stat_mis_q, stat_mis_d, stat_cmis_q, stat_cmis_d;
  logic [1:0]  inc_pred, inc_mis, inc_cmis;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + 33'(inc);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // Counts the feedback lanes currently presented to the predictor.
  always_comb begin
    inc_pred = '0;
    inc_mis  = '0;
    inc_cmis = '0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      inc_pred = inc_pred + 2'(fb_valid_q[k]);
      inc_mis  = inc_mis  + 2'(fb_valid_q[k] & fb_mis_q[k]);
      inc_cmis = inc_cmis + 2'(fb_valid_q[k] & fb_mis_q[k] & fb_conf_q[k]);
    end
    stat_pred_d = sat_add(stat_pred_q, inc_pred);
    stat_mis_d  = sat_add(stat_mis_q, inc_mis);
    stat_cmis_d = sat_add(stat_cmis_q, inc_cmis);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_pred_q <= '0;
      stat_mis_q  <= '0;
      stat_cmis_q <= '0;
    end else begin
      stat_pred_q <= stat_pred_d;
      stat_mis_q  <= stat_mis_d;
      stat_cmis_q <= stat_cmis_d;
    end
  end

  assign stat_pred_o         = stat_pred_q;
  assign stat_mispred_o      = stat_mis_q;
  assign stat_conf_mispred_o = stat_cmis_q;
`endif

endmodule

// File: tb/tb_vp_validate_unit.sv
// Scoreboard bench for vp_validate_unit: a queue model of in-flight predictions predicts each cycle's feedback.
module tb_vp_validate_unit;
  import vp_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  vp_validate_unit_if #(.P_NUM_PRED(NP)) bus ();

  vp_validate_unit #(
    .P_NUM_PRED   (NP),
    .P_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic        conf;
  } ment_t;

  typedef struct {
    logic [1:0]       vld;
    logic [1:0]       mis;
    logic [1:0]       conf;
    logic [1:0][31:0] act;
    logic [1:0][31:0] pc;
  } fbx_t;

  ment_t      mq[$];
  fbx_t       exp_q[$];
  logic [2:0] err_m;
  int         n_run  = 0;
  int         n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    bus.pred_pc_i     = '0;
    bus.pred_result_i = '0;
    bus.pred_conf_i   = '0;
    bus.pred_valid_i  = '0;
    bus.exe_pc_i      = '0;
    bus.exe_result_i  = '0;
    bus.exe_valid_i   = '0;
    bus.flush_i       = 1'b0;
  endtask

  task automatic set_pred(input int k, input logic [31:0] pc, input logic [31:0] res, input logic conf);
    bus.pred_valid_i[k]  = 1'b1;
    bus.pred_pc_i[k]     = pc;
    bus.pred_result_i[k] = res;
    bus.pred_conf_i[k]   = conf;
  endtask

  task automatic set_exe(input int k, input logic [31:0] pc, input logic [31:0] res);
    bus.exe_valid_i[k]  = 1'b1;
    bus.exe_pc_i[k]     = pc;
    bus.exe_result_i[k] = res;
  endtask

  // Model: exe lanes consume pre-cycle contents, then flush or append predictions.
  task automatic tick(input string tag);
    fbx_t  x;
    ment_t e;
    x = '{vld: '0, mis: '0, conf: '0, act: '0, pc: '0};
    for (int k = 0; k < NP; k++) begin
      if (bus.exe_valid_i[k]) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          if (e.pc == bus.exe_pc_i[k]) begin
            x.vld[k]  = 1'b1;
            x.mis[k]  = (e.res != bus.exe_result_i[k]);
            x.conf[k] = e.conf;
            x.act[k]  = bus.exe_result_i[k];
            x.pc[k]   = e.pc;
          end else begin
            err_m[2] = 1'b1;
          end
        end else begin
          err_m[1] = 1'b1;
        end
      end
    end
    if (bus.flush_i) begin
      mq.delete();
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (bus.pred_valid_i[k]) begin
          if (mq.size() < DEPTH) mq.push_back('{pc: bus.pred_pc_i[k], res: bus.pred_result_i[k], conf: bus.pred_conf_i[k]});
          else err_m[0] = 1'b1;
        end
      end
    end
    exp_q.push_back(x);
    @(posedge clk_i);
    #1;
    x = exp_q.pop_front();
    check_val({tag, ".vld"}, bus.fb_valid_o, x.vld);
    check_val({tag, ".mis"}, bus.fb_mispredict_o & x.vld, x.mis);
    check_val({tag, ".conf"}, bus.fb_conf_o & x.vld, x.conf);
    for (int k = 0; k < NP; k++) begin
      if (x.vld[k]) begin
        check_val({tag, ".act"}, bus.fb_actual_o[k], x.act[k]);
        check_val({tag, ".pc"}, bus.fb_pc_o[k], x.pc[k]);
      end
    end
    check_val({tag, ".err"}, bus.err_o, err_m);
    check_val({tag, ".full"}, bus.full_o, (DEPTH - mq.size()) < NP);
    clear_in();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_in();
    mq.delete();
    exp_q.delete();
    err_m = '0;
    @(posedge clk_i);
    #1;
    check_val("rst.vld", bus.fb_valid_o, 2'b00);
    check_val("rst.err", bus.err_o, 3'b000);
    check_val("rst.full", bus.full_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    int idx;
    logic [31:0] pc;
    clear_in();
    err_m = '0;
    do_reset();

    // Correct prediction with saturated confidence.
    set_pred(0, 32'h100, 32'd5, 1'b1);
    tick("r030a");
    set_exe(0, 32'h100, 32'd5);
    tick("r030b");
    check_val("r030.vld", bus.fb_valid_o, 2'b01);
    check_val("r030.mis", bus.fb_mispredict_o[0], 1'b0);
    check_val("r030.conf", bus.fb_conf_o[0], 1'b1);

    // Value mispredict.
    set_pred(0, 32'h200, 32'd7, 1'b0);
    tick("r031a");
    set_exe(0, 32'h200, 32'd9);
    tick("r031b");
    check_val("r031.mis", bus.fb_mispredict_o[0], 1'b1);
    check_val("r031.act", bus.fb_actual_o[0], 32'd9);

    // Fill, overflow, then simultaneous dual push/pop at full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_pred(0, 32'h1000 + i, 32'd100 + i, i[0]);
      tick("fill");
    end
    check_val("r032.full", bus.full_o, 1'b1);
    set_pred(0, 32'h2000, 32'd1, 1'b0);
    tick("r032.ovf");
    check_val("r032.err0", bus.err_o, 3'b001);
    set_exe(0, mq[0].pc, mq[0].res);
    set_exe(1, mq[1].pc, mq[1].res + 1);
    set_pred(0, 32'h3000, 32'd30, 1'b1);
    set_pred(1, 32'h3001, 32'd31, 1'b0);
    tick("r032.dual");
    check_val("r032.errkeep", bus.err_o, 3'b001);
    check_val("r032.fullkeep", bus.full_o, 1'b1);
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_exe(0, mq[0].pc, mq[0].res);
      set_exe(1, mq[1].pc, mq[1].res);
      tick("drain");
    end
    check_val("r032.last", bus.fb_pc_o[1], 32'h3001);

    // Dual exe with a single entry.
    do_reset();
    set_pred(0, 32'h400, 32'd4, 1'b0);
    tick("r033a");
    set_exe(0, 32'h400, 32'd4);
    set_exe(1, 32'h404, 32'd4);
    tick("r033b");
    check_val("r033.vld", bus.fb_valid_o, 2'b01);
    check_val("r033.err", bus.err_o, 3'b010);

    // Flush with concurrent exe and pred.
    do_reset();
    set_pred(0, 32'h500, 32'd50, 1'b1);
    set_pred(1, 32'h504, 32'd51, 1'b0);
    tick("r034a");
    set_pred(1, 32'h508, 32'd52, 1'b1);
    tick("r034b");
    set_exe(0, 32'h500, 32'd50);
    set_pred(0, 32'h50c, 32'd53, 1'b0);
    bus.flush_i = 1'b1;
    tick("r034.flush");
    check_val("r034.vld", bus.fb_valid_o, 2'b01);
    check_val("r034.pc", bus.fb_pc_o[0], 32'h500);
    set_exe(0, 32'h504, 32'd51);
    tick("r034.udf");
    check_val("r034.udfvld", bus.fb_valid_o, 2'b00);
    check_val("r034.udferr", bus.err_o, 3'b010);

    // PC mismatch pops the entry without feedback.
    do_reset();
    set_pred(0, 32'h600, 32'd6, 1'b1);
    set_pred(1, 32'h604, 32'd7, 1'b1);
    tick("pcm.a");
    set_exe(0, 32'h608, 32'd6);
    tick("pcm.b");
    check_val("pcm.err", bus.err_o, 3'b100);
    set_exe(0, 32'h604, 32'd7);
    tick("pcm.c");
    check_val("pcm.next", bus.fb_valid_o, 2'b01);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idx = 0;
      for (int k = 0; k < NP; k++) begin
        if ($urandom_range(0, 2) != 0) set_pred(k, $urandom & 32'hFFFC, $urandom_range(0, 3), 1'($urandom));
        if ($urandom_range(0, 2) == 0) begin
          if (idx < mq.size()) begin
            pc = ($urandom_range(0, 9) == 0) ? (mq[idx].pc ^ 32'h4) : mq[idx].pc;
            set_exe(k, pc, ($urandom_range(0, 1) == 0) ? mq[idx].res : 32'($urandom_range(0, 3)));
          end else begin
            set_exe(k, $urandom, $urandom);
          end
          idx++;
        end
      end
      bus.flush_i = ($urandom_range(0, 31) == 0);
      tick("rand");
    end

    // Asynchronous reset between edges clears outputs immediately.
    do_reset();
    set_exe(0, 32'h700, 32'd0);
    tick("r035.udf");
    set_pred(0, 32'h710, 32'd1, 1'b0);
    tick("r035.push");
    set_exe(0, 32'h710, 32'd1);
    tick("r035.hit");
    check_val("r035.pre", bus.fb_valid_o, 2'b01);
    #2;
    rst_i = 1'b1;
    #1;
    check_val("r035.vld", bus.fb_valid_o, 2'b00);
    check_val("r035.err", bus.err_o, 3'b000);
    check_val("r035.full", bus.full_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mq.delete();
    err_m = '0;
    set_exe(0, 32'h710, 32'd1);
    tick("r035.after");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
